// File: rtl/per_core.sv
// Single-sample perceptron training core: reads one sample and the weight
// vector, forms the Q8.8 weighted sum and writes back corrected weights on a misprediction.
`timescale 1ns/1ps
module per_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  control,
    output logic        mem_x1_ena,
    output logic        mem_x2_ena,
    output logic        mem_label_ena,
    input  logic [10:0] mem_x1_addr,
    input  logic [10:0] mem_x2_addr,
    input  logic [10:0] mem_label_addr,
    input  logic [15:0] mem_x1_data,
    input  logic [15:0] mem_x2_data,
    input  logic [15:0] mem_label_data,
    output logic        mem_x1_w,
    output logic        mem_x2_w,
    output logic        mem_label_w,
    output logic        mem_w_ena,
    output logic [6:0]  mem_w_addr,
    input  logic [15:0] mem_w_data,
    output logic        mem_w_w,
    output logic [15:0] mem_w_data_out
);

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, MAC, CHECK, WR0, WR1, WR2, DONE
    } state_t;

    state_t state_reg, state_next;

    logic signed [15:0] x1_reg, x2_reg, w0_reg, w1_reg, w2_reg;
    logic               label_neg_reg;
    logic signed [18:0] sum_reg;

    logic signed [31:0] prod1, prod2, p1, p2, bias_term, sum_full;
    logic        [15:0] sum_sat;
    logic               pred_neg, mismatch;
    logic signed [16:0] w0_sum, w1_sum, w2_sum;
    logic        [15:0] w0_new, w1_new, w2_new;
    logic               sample_ena;

    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15])
            return v[16] ? 16'h8000 : 16'h7FFF;
        return v[15:0];
    endfunction

    assign prod1     = w1_reg * x1_reg;
    assign prod2     = w2_reg * x2_reg;
    assign p1        = prod1 >>> 8;
    assign p2        = prod2 >>> 8;
    assign bias_term = control[2] ? {{16{w0_reg[15]}}, w0_reg} : 32'sd0;
    // Only the low 19 bits are kept in sum_reg; the wider add is equivalent modulo 2^19.
    assign sum_full  = bias_term + p1 + p2;

    always_comb begin
        if (sum_reg > 19'sd32767)
            sum_sat = 16'h7FFF;
        else if (sum_reg < -19'sd32768)
            sum_sat = 16'h8000;
        else
            sum_sat = sum_reg[15:0];
    end

    assign pred_neg = sum_sat[15];
    assign mismatch = pred_neg != label_neg_reg;

    assign w0_sum = label_neg_reg ? {w0_reg[15], w0_reg} - 17'sd256
                                  : {w0_reg[15], w0_reg} + 17'sd256;
    assign w1_sum = label_neg_reg ? {w1_reg[15], w1_reg} - {x1_reg[15], x1_reg}
                                  : {w1_reg[15], w1_reg} + {x1_reg[15], x1_reg};
    assign w2_sum = label_neg_reg ? {w2_reg[15], w2_reg} - {x2_reg[15], x2_reg}
                                  : {w2_reg[15], w2_reg} + {x2_reg[15], x2_reg};
    assign w0_new = sat16(w0_sum);
    assign w1_new = sat16(w1_sum);
    assign w2_new = sat16(w2_sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            x1_reg        <= '0;
            x2_reg        <= '0;
            w0_reg        <= '0;
            w1_reg        <= '0;
            w2_reg        <= '0;
            label_neg_reg <= 1'b0;
            sum_reg       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                RD1: begin
                    x1_reg        <= mem_x1_data;
                    x2_reg        <= mem_x2_data;
                    label_neg_reg <= mem_label_data[15];
                    w0_reg        <= mem_w_data;
                end
                RD2:     w1_reg  <= mem_w_data;
                RD3:     w2_reg  <= mem_w_data;
                MAC:     sum_reg <= sum_full[18:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state_reg;
        sample_ena     = 1'b0;
        mem_w_ena      = 1'b0;
        mem_w_w        = 1'b0;
        mem_w_addr     = 7'd0;
        mem_w_data_out = 16'h0000;
        case (state_reg)
            IDLE: if (control[0]) state_next = RD0;
            RD0: begin
                sample_ena = 1'b1;
                mem_w_ena  = 1'b1;
                state_next = RD1;
            end
            RD1: begin
                sample_ena = 1'b1;
                mem_w_ena  = 1'b1;
                mem_w_addr = 7'd1;
                state_next = RD2;
            end
            RD2: begin
                mem_w_ena  = 1'b1;
                mem_w_addr = 7'd2;
                state_next = RD3;
            end
            RD3: state_next = MAC;
            MAC: state_next = CHECK;
            CHECK: begin
                if (!mismatch || !control[1])
                    state_next = DONE;
                else if (control[2])
                    state_next = WR0;
                else
                    state_next = WR1;
            end
            WR0: begin
                mem_w_ena      = 1'b1;
                mem_w_w        = 1'b1;
                mem_w_data_out = w0_new;
                state_next     = WR1;
            end
            WR1: begin
                mem_w_ena      = 1'b1;
                mem_w_w        = 1'b1;
                mem_w_addr     = 7'd1;
                mem_w_data_out = w1_new;
                state_next     = WR2;
            end
            WR2: begin
                mem_w_ena      = 1'b1;
                mem_w_w        = 1'b1;
                mem_w_addr     = 7'd2;
                mem_w_data_out = w2_new;
                state_next     = DONE;
            end
            DONE: if (!control[0]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_x1_ena    = sample_ena;
    assign mem_x2_ena    = sample_ena;
    assign mem_label_ena = sample_ena;
    assign mem_x1_w      = 1'b0;
    assign mem_x2_w      = 1'b0;
    assign mem_label_w   = 1'b0;

    // Addresses are routed to the RAMs externally; the core never consumes them.
    logic unused_bits;
    assign unused_bits = ^{mem_x1_addr, mem_x2_addr, mem_label_addr, control[3],
                           sum_full[31:19], sum_sat[14:0], mem_label_data[14:0]};

endmodule

// File: tb/tb_per_core.sv
// Scoreboard bench for per_core: RAM models, an integer reference model and a
// per-cycle expected output trace compared on the falling edge.
`timescale 1ns/1ps
module tb_per_core;

    typedef logic [30:0] trace_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  control = 4'h0;
    logic        mem_x1_ena, mem_x2_ena, mem_label_ena;
    logic [10:0] mem_x1_addr = '0, mem_x2_addr = '0, mem_label_addr = '0;
    logic [15:0] mem_x1_data = '0, mem_x2_data = '0, mem_label_data = '0;
    logic        mem_x1_w, mem_x2_w, mem_label_w;
    logic        mem_w_ena, mem_w_w;
    logic [6:0]  mem_w_addr;
    logic [15:0] mem_w_data = '0;
    logic [15:0] mem_w_data_out;

    logic [15:0] x1_mem [0:2047];
    logic [15:0] x2_mem [0:2047];
    logic [15:0] lab_mem [0:2047];
    logic [15:0] wmem [0:127];
    logic [15:0] w_init [0:2];
    logic        load_req = 1'b0;

    int     n_checks = 0;
    int     n_pass = 0;
    trace_t exp_q[$];
    logic [15:0] exp_w [0:2];

    always #5 clk = ~clk;

    per_core dut (
        .clk(clk), .rst(rst), .control(control),
        .mem_x1_ena(mem_x1_ena), .mem_x2_ena(mem_x2_ena), .mem_label_ena(mem_label_ena),
        .mem_x1_addr(mem_x1_addr), .mem_x2_addr(mem_x2_addr), .mem_label_addr(mem_label_addr),
        .mem_x1_data(mem_x1_data), .mem_x2_data(mem_x2_data), .mem_label_data(mem_label_data),
        .mem_x1_w(mem_x1_w), .mem_x2_w(mem_x2_w), .mem_label_w(mem_label_w),
        .mem_w_ena(mem_w_ena), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_w_w(mem_w_w), .mem_w_data_out(mem_w_data_out)
    );

    always @(posedge clk) begin
        if (mem_x1_ena)    mem_x1_data    <= x1_mem[mem_x1_addr];
        if (mem_x2_ena)    mem_x2_data    <= x2_mem[mem_x2_addr];
        if (mem_label_ena) mem_label_data <= lab_mem[mem_label_addr];
        if (load_req) begin
            wmem[0] <= w_init[0];
            wmem[1] <= w_init[1];
            wmem[2] <= w_init[2];
        end else if (mem_w_ena) begin
            if (mem_w_w) wmem[mem_w_addr] <= mem_w_data_out;
            else         mem_w_data <= wmem[mem_w_addr];
        end
    end

    function automatic trace_t obs();
        return {mem_x1_ena, mem_x2_ena, mem_label_ena, mem_x1_w, mem_x2_w, mem_label_w,
                mem_w_ena, mem_w_w, mem_w_addr, mem_w_data_out};
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model(input logic [3:0] ctrl,
                                  input logic [15:0] w0, w1, w2, x1, x2, lab,
                                  output bit upd, output logic [15:0] n0, n1, n2);
        int iw0, iw1, iw2, ix1, ix2, p1, p2, s;
        logic signed [18:0] s19;
        bit cls_pos, pred_pos;
        iw0 = int'($signed(w0)); iw1 = int'($signed(w1)); iw2 = int'($signed(w2));
        ix1 = int'($signed(x1)); ix2 = int'($signed(x2));
        p1 = (iw1 * ix1) >>> 8;
        p2 = (iw2 * ix2) >>> 8;
        s = (ctrl[2] ? iw0 : 0) + p1 + p2;
        s19 = s[18:0];
        pred_pos = (s19 >= 0);
        cls_pos = (lab[15] == 1'b0);
        upd = ctrl[1] && (pred_pos != cls_pos);
        n0 = 16'(clamp(cls_pos ? iw0 + 256 : iw0 - 256));
        n1 = 16'(clamp(cls_pos ? iw1 + ix1 : iw1 - ix1));
        n2 = 16'(clamp(cls_pos ? iw2 + ix2 : iw2 - ix2));
    endfunction

    // Loads memories, pushes the expected per-cycle trace, then asserts start.
    // Entered and left on a falling edge; the next rising edge enters RD0.
    task automatic start_run(input logic [3:0] ctrl,
                             input logic [15:0] w0, w1, w2, x1, x2, lab, input int extra);
        logic [10:0] a1, a2, a3;
        bit upd;
        logic [15:0] n0, n1, n2;
        a1 = 11'($urandom_range(0, 2047));
        a2 = 11'($urandom_range(0, 2047));
        a3 = 11'($urandom_range(0, 2047));
        x1_mem[a1] = x1; x2_mem[a2] = x2; lab_mem[a3] = lab;
        mem_x1_addr = a1; mem_x2_addr = a2; mem_label_addr = a3;
        w_init[0] = w0; w_init[1] = w1; w_init[2] = w2;
        load_req = 1'b1;
        model(ctrl, w0, w1, w2, x1, x2, lab, upd, n0, n1, n2);
        exp_q.push_back({3'b111, 3'b000, 1'b1, 1'b0, 7'd0, 16'h0000});
        exp_q.push_back({3'b111, 3'b000, 1'b1, 1'b0, 7'd1, 16'h0000});
        exp_q.push_back({3'b000, 3'b000, 1'b1, 1'b0, 7'd2, 16'h0000});
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        if (upd && ctrl[2]) exp_q.push_back({6'b0, 1'b1, 1'b1, 7'd0, n0});
        if (upd) begin
            exp_q.push_back({6'b0, 1'b1, 1'b1, 7'd1, n1});
            exp_q.push_back({6'b0, 1'b1, 1'b1, 7'd2, n2});
        end
        for (int i = 0; i <= extra; i++) exp_q.push_back('0);
        exp_w[0] = (upd && ctrl[2]) ? n0 : w0;
        exp_w[1] = upd ? n1 : w1;
        exp_w[2] = upd ? n2 : w2;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        control = ctrl;
    endtask

    task automatic test_reset();
        trace_t got, e;
        int idx;
        rst = 1'b0;
        start_run(4'hF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = obs();
            n_checks++;
            if (got !== '0) $display("FAIL reset_hold cyc%0d: got %h expected 0", i, got);
            else n_pass++;
        end
        rst = 1'b1;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = obs();
            n_checks++;
            if (got !== e) $display("FAIL reset_run step%0d: got %h expected %h", idx, got, e);
            else n_pass++;
            idx++;
        end
        control[0] = 1'b0;
        @(negedge clk);
    endtask

    // One generic scenario runner per named feature keeps its own comparisons.
    task automatic test_runs(input string name, input int nvec,
                             input logic [3:0] c [0:1], input logic [15:0] v [0:1][0:5],
                             input int extra);
        trace_t got, e;
        int idx;
        for (int k = 0; k < nvec; k++) begin
            start_run(c[k], v[k][0], v[k][1], v[k][2], v[k][3], v[k][4], v[k][5], extra);
            idx = 0;
            while (exp_q.size() > 0) begin
                @(posedge clk); @(negedge clk);
                e = exp_q.pop_front(); got = obs();
                n_checks++;
                if (got !== e) $display("FAIL %s v%0d step%0d: got %h expected %h", name, k, idx, got, e);
                else n_pass++;
                idx++;
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wmem[i] !== exp_w[i])
                    $display("FAIL %s v%0d weight%0d: got %h expected %h", name, k, i, wmem[i], exp_w[i]);
                else n_pass++;
            end
            control[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_midrun_reset();
        trace_t got, e;
        int idx;
        start_run(4'b0111, 16'h0040, 16'h0010, 16'h0020, 16'h0100, 16'h0200, 16'hFFFF, 2);
        // Observe RD0..WR1 (8 cycles), then pull reset in the middle of WR1.
        for (idx = 0; idx < 8; idx++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = obs();
            n_checks++;
            if (got !== e) $display("FAIL midrun step%0d: got %h expected %h", idx, got, e);
            else n_pass++;
        end
        #1 rst = 1'b0;
        #1 got = obs();
        n_checks++;
        if (got !== '0) $display("FAIL midrun_async_clear: got %h expected 0", got);
        else n_pass++;
        exp_q.delete();
        control = 4'h0;
        @(negedge clk);
        n_checks++;
        if (wmem[0] !== 16'hFF40) $display("FAIL midrun_w0_written: got %h expected ff40", wmem[0]);
        else n_pass++;
        n_checks++;
        if (wmem[1] !== 16'h0010) $display("FAIL midrun_w1_kept: got %h expected 0010", wmem[1]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = obs();
        n_checks++;
        if (got !== '0) $display("FAIL midrun_idle: got %h expected 0", got);
        else n_pass++;
        start_run(4'b0111, 16'hFF40, 16'h0010, 16'h0020, 16'h0100, 16'h0200, 16'hFFFF, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = obs();
            n_checks++;
            if (got !== e) $display("FAIL midrun_rerun step%0d: got %h expected %h", idx, got, e);
            else n_pass++;
            idx++;
        end
        control[0] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  c [0:1];
        logic [15:0] v [0:1][0:5];
        for (int i = 0; i < 2048; i++) begin
            x1_mem[i] = '0; x2_mem[i] = '0; lab_mem[i] = '0;
        end
        for (int i = 0; i < 128; i++) wmem[i] = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();

        c[0] = 4'b0111; c[1] = 4'b0111;
        v[0] = '{16'h0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'h0001};
        v[1] = v[0];
        test_runs("no_update", 1, c, v, 2);

        v[0] = '{16'h0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'hFFFF};
        test_runs("update", 1, c, v, 2);

        v[0] = '{16'h0, 16'h7F00, 16'h0, 16'h0200, 16'h0, 16'hFFFF};
        v[1] = '{16'h7F80, 16'h8100, 16'h8000, 16'hFE00, 16'h0400, 16'h0001};
        test_runs("saturation", 2, c, v, 1);

        c[0] = 4'b0001; c[1] = 4'b0011;
        v[0] = '{16'h0040, 16'h0010, 16'h0020, 16'h0100, 16'h0200, 16'hFFFF};
        v[1] = v[0];
        test_runs("gating", 2, c, v, 1);

        c[0] = 4'b0111; c[1] = 4'b0111;
        v[0] = '{16'h0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'h0001};
        v[1] = '{16'h0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'hFFFF};
        test_runs("restart", 2, c, v, 6);

        test_midrun_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/per_core.md
# per_core

Perceptron training core for one sample per run. On a start command it reads one sample (x1, x2, label) from the external sample memories, reads the weight vector (w0 bias, w1, w2) from the weight memory, and computes the Q8.8 weighted sum. If the predicted sign differs from the label, it writes the corrected weights back. It sits between the top-level sequencer, which supplies sample addresses and commands, and four external single-port synchronous RAMs: x1, x2, label and weight.

## Interface
Parameters:
- none (data width fixed at 16, weight address width 7, sample address width 11)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- control  in  4  [0] start, [1] update enable, [2] bias enable, [3] reserved (ignored)
- mem_x1_ena / mem_x2_ena / mem_label_ena  out  1  sample-memory read enables
- mem_x1_addr / mem_x2_addr / mem_label_addr  in  11  sample address, supplied externally and held stable during a run
- mem_x1_data / mem_x2_data / mem_label_data  in  16  sample-memory read data, valid 1 cycle after an enabled edge
- mem_x1_w / mem_x2_w / mem_label_w  out  1  write strobes, tied 0 (core never writes sample memories)
- mem_w_ena  out  1  weight-memory enable
- mem_w_addr  out  7  weight address: 0=w0, 1=w1, 2=w2
- mem_w_data  in  16  weight read data, 1-cycle latency
- mem_w_w  out  1  weight write strobe
- mem_w_data_out  out  16  weight write data

## Operation
- Number format: all data is 16-bit two's-complement Q8.8 (0x0100 = 1.0).
- Label sign: label[15]=0 is class +1; otherwise class −1.
- States: IDLE, RD0, RD1, RD2, RD3, MAC, CHECK, WR0, WR1, WR2, DONE.
- IDLE: all enables and strobes are 0. Advance to RD0 when control[0]=1.
- RD0: assert the three sample enables and mem_w_ena; mem_w_addr=0.
- RD1: keep all enables asserted; mem_w_addr=1. At the end of the cycle, capture x1, x2, label and w0.
- RD2: assert mem_w_ena only; mem_w_addr=2. Capture w1.
- RD3: deassert all enables. Capture w2.
- MAC:
  - p1 = (w1·x1) >>> 8 and p2 = (w2·x2) >>> 8, using 32-bit signed products and arithmetic shifts.
  - b = w0 if control[2]=1, else 0.
  - sum = b + p1 + p2, computed in 19 bits and registered.
- CHECK:
  - pred = +1 if sum ≥ 0, else −1.
  - Go to DONE if pred equals the label class or control[1]=0.
  - Otherwise go to WR0, or to WR1 when control[2]=0 (the bias is not updated).
- Update values (each saturated to the range 0x8000..0x7FFF):
  - Label class +1: w0' = w0 + 0x0100, w1' = w1 + x1, w2' = w2 + x2.
  - Label class −1: w0' = w0 − 0x0100, w1' = w1 − x1, w2' = w2 − x2.
- WR0/WR1/WR2: mem_w_ena=1, mem_w_w=1, mem_w_addr=0/1/2, mem_w_data_out = w0'/w1'/w2'; one word per cycle.
- DONE: all strobes are 0. Return to IDLE only when control[0]=0, so a new run needs control[0] to drop and rise again.
- The sum also saturates to 16 bits before the sign test, which does not change the sign.

## Timing
- Reset (rst=0, asynchronous): state = IDLE; every output, the captured registers and sum are all 0. This applies at any point, including mid-write; a partially written weight set is left as written.
- Start latency: RD0 begins on the first edge at which control[0]=1 is seen in IDLE.
- Run length without update: RD0 → DONE is 7 cycles.
- Run length with full update: 10 cycles.
- All runs finish in under 30 cycles.
- control[1] and control[2] are sampled in CHECK/MAC. Changes to them after those states do not affect the run in progress.
- control[0] falling mid-run does not abort the run; the core completes it, then passes through DONE back to IDLE.
- Sample addresses must stay stable from RD0 through RD1.

## Test plan
- Reset: hold rst=0 with control=4'hF → all outputs 0 and no memory enables for 20 cycles; release → RD0 is entered on the next edge.
- No update on match: weights 0, x1=0x0100, x2=0x0200, label=0x0001 → sum=0, pred +1; no mem_w_w pulse; DONE after 7 cycles.
- Update on mismatch: same sample with label=0xFFFF → three writes to addresses 0,1,2 with data 0xFF00, 0xFF00, 0xFE00 on consecutive cycles.
- Saturation: w1=0x7F00, x1=0x0200, w0=w2=0, label=0xFFFF → sum positive, mismatch; w1' = 0x7D00. Then with w1=0x7F00, x1=0x0200 negated case (x1=0xFE00, w1 large negative 0x8100, label +1) → w1' clamps to 0x8000.
- Gating: control=4'b0001 (update and bias disabled) on a mismatching sample → no writes; control=4'b0011 → writes only to addresses 1 and 2.
- Restart and mid-run reset: keep control[0]=1 after DONE → no second run; drop then raise control[0] → a new run starts. Pulse rst=0 during WR1 → outputs drop to 0 asynchronously and the core restarts from IDLE.
